// File: rtl/cdb_arb_rr_pkg.sv
// Shared types and defaults for the common-data-bus arbiter: source request,
// ROB completion packet and CDB/PRF writeback packet.
package cdb_arb_rr_pkg;

  localparam int ROB_IDX_W     = 6;
  localparam int PRN_W         = 6;
  localparam int XLEN          = 32;
  localparam int CDB_BUF_DEPTH = 2;
  localparam int CDB_LANES     = 2;

  typedef logic [ROB_IDX_W-1:0] ROB_IDX;
  typedef logic [PRN_W-1:0]     PRN;
  typedef logic [XLEN-1:0]      DATA;

  typedef struct packed {
    ROB_IDX robn;
    PRN     dest_prn;
    logic   has_dest;
    logic   take_branch;
    DATA    value;
  } CDB_REQ;

  typedef struct packed {
    ROB_IDX robn;
    logic   executed;
    logic   branch_taken;
    DATA    target_addr;
  } FU_ROB_PACKET;

  typedef struct packed {
    PRN  dest_prn;
    DATA value;
  } CDB_PACKET;

  // Index width that never collapses to zero bits for single-entry structures.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_arb_rr_if.sv
// Source-side handshake and broadcast lanes of the CDB arbiter; the arbiter
// takes the slave side, the functional units / ROB / PRF take the master side.
interface cdb_arb_rr_if #(
  parameter int NUM_SRC = 8,
  parameter int LANES   = cdb_arb_rr_pkg::CDB_LANES
);

  logic [NUM_SRC-1:0]                        src_valid;
  cdb_arb_rr_pkg::CDB_REQ [NUM_SRC-1:0]       src_req;
  logic [NUM_SRC-1:0]                        src_ready;
  cdb_arb_rr_pkg::FU_ROB_PACKET [LANES-1:0]   fu_rob_packet;
  cdb_arb_rr_pkg::CDB_PACKET [LANES-1:0]      cdb_output;

  modport master (
    output src_valid,
    output src_req,
    input  src_ready,
    input  fu_rob_packet,
    input  cdb_output
  );

  modport slave (
    input  src_valid,
    input  src_req,
    output src_ready,
    output fu_rob_packet,
    output cdb_output
  );

endinterface

// File: rtl/cdb_arb_rr_src_fifo.sv
// Per-source holding FIFO for the CDB arbiter; squash and reset both empty it
// in one cycle without touching the stored payloads.
module cdb_src_fifo
  import cdb_arb_rr_pkg::*;
#(
  parameter int BUF_DEPTH = CDB_BUF_DEPTH
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               squash,
  input  logic                               enq,
  input  CDB_REQ                             enq_data,
  input  logic                               deq,
  output CDB_REQ                             head,
  output logic [$clog2(BUF_DEPTH + 1)-1:0]   count,
  output logic                               full,
  output logic                               empty
);

  localparam int PTR_W = idx_width(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  CDB_REQ           mem [BUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_enq;
  logic             do_deq;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full   = (count == CNT_W'(BUF_DEPTH));
  assign empty  = (count == '0);
  assign do_enq = enq & ~full;
  assign do_deq = deq & ~empty;
  assign head   = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset || squash) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= next_ptr(wr_ptr);
      if (do_deq) rd_ptr <= next_ptr(rd_ptr);
      if (do_enq != do_deq) count <= do_enq ? count + 1'b1 : count - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_enq && !reset && !squash) mem[wr_ptr] <= enq_data;
  end

endmodule

// File: rtl/cdb_arb_rr.sv
// CDB arbiter: buffers each source in a small FIFO and grants up to LANES heads
// per cycle. Define CDB_ROUND_ROBIN_EN for rotating priority; otherwise source 0 wins.
module cdb_arb_rr
  import cdb_arb_rr_pkg::*;
#(
  parameter int NUM_SRC   = 8,
  parameter int LANES     = CDB_LANES,
  parameter int BUF_DEPTH = CDB_BUF_DEPTH
) (
  input logic         clock,
  input logic         reset,
  input logic         squash,
  cdb_arb_rr_if.slave bus
);

  localparam int SRC_W = idx_width(NUM_SRC);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int USE_W = $clog2(LANES + 1);

  logic               flush;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] enq;
  logic [NUM_SRC-1:0] ready;
  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] full;
  logic [CNT_W-1:0]   count [NUM_SRC];
  CDB_REQ             head [NUM_SRC];
  logic [SRC_W-1:0]   ptr;
  logic [SRC_W-1:0]   lane_src [LANES];
  logic [LANES-1:0]   lane_vld;

  assign flush         = reset | squash;
  assign bus.src_ready = ready;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      ready[i] = ~full[i];
      req[i]   = ~empty[i];
      enq[i]   = bus.src_valid[i] & ready[i] & ~flush;
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    cdb_src_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .squash   (squash),
      .enq      (enq[i]),
      .enq_data (bus.src_req[i]),
      .deq      (grant[i]),
      .head     (head[i]),
      .count    (count[i]),
      .full     (full[i]),
      .empty    (empty[i])
    );

    always_ff @(posedge clock) begin
      if (!reset) assert (full[i] == (count[i] == CNT_W'(BUF_DEPTH)));
    end
  end

  // Scan from ptr with wraparound; lanes fill in scan order, one per source.
  always_comb begin
    logic [SRC_W:0]   pos;
    logic [SRC_W-1:0] idx;
    logic [USE_W-1:0] used;
    grant    = '0;
    lane_vld = '0;
    used     = '0;
    pos      = '0;
    idx      = '0;
    for (int l = 0; l < LANES; l++) lane_src[l] = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      pos = {1'b0, ptr} + (SRC_W + 1)'(k);
      if (pos >= (SRC_W + 1)'(NUM_SRC)) pos = pos - (SRC_W + 1)'(NUM_SRC);
      idx = pos[SRC_W-1:0];
      if (req[idx] && !flush && used < USE_W'(LANES)) begin
        grant[idx] = 1'b1;
        for (int l = 0; l < LANES; l++) begin
          if (used == USE_W'(l)) begin
            lane_src[l] = idx;
            lane_vld[l] = 1'b1;
          end
        end
        used = used + 1'b1;
      end
    end
  end

`ifdef CDB_ROUND_ROBIN_EN
  logic [SRC_W-1:0] ptr_next;

  // The highest valid lane holds the last source granted in scan order.
  always_comb begin
    ptr_next = ptr;
    for (int l = 0; l < LANES; l++) begin
      if (lane_vld[l]) ptr_next = (lane_src[l] == SRC_W'(NUM_SRC - 1)) ? '0 : lane_src[l] + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (flush) ptr <= '0;
    else       ptr <= ptr_next;
  end
`else
  assign ptr = '0;
`endif

  always_comb begin
    CDB_REQ h;
    for (int l = 0; l < LANES; l++) begin
      h                     = head[lane_src[l]];
      bus.fu_rob_packet[l]  = '0;
      bus.cdb_output[l]     = '0;
      if (lane_vld[l]) begin
        bus.fu_rob_packet[l].robn         = h.robn;
        bus.fu_rob_packet[l].executed     = 1'b1;
        bus.fu_rob_packet[l].branch_taken = h.take_branch;
        bus.fu_rob_packet[l].target_addr  = h.value;
        if (h.has_dest) begin
          bus.cdb_output[l].dest_prn = h.dest_prn;
          bus.cdb_output[l].value    = h.value;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arb_rr.sv
// Directed bench for cdb_arb_rr with 4 sources, 2 lanes, depth 2; expectations
// follow the build's priority mode (CDB_ROUND_ROBIN_EN defined or not).
module tb_cdb_arb_rr;
  import cdb_arb_rr_pkg::*;

  localparam int NS = 4;
  localparam int NL = 2;
  localparam int BD = 2;

  logic clock = 1'b0;
  logic reset;
  logic squash;
  int   checks = 0;
  int   passed = 0;

  cdb_arb_rr_if #(.NUM_SRC(NS), .LANES(NL)) bus ();

  cdb_arb_rr #(.NUM_SRC(NS), .LANES(NL), .BUF_DEPTH(BD)) dut (
    .clock  (clock),
    .reset  (reset),
    .squash (squash),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  function automatic CDB_REQ mk(input int robn, input int prn, input bit hd, input bit tb, input int val);
    CDB_REQ r;
    r.robn        = ROB_IDX'(robn);
    r.dest_prn    = PRN'(prn);
    r.has_dest    = hd;
    r.take_branch = tb;
    r.value       = DATA'(val);
    return r;
  endfunction

  task automatic idle_inputs();
    bus.src_valid = '0;
    bus.src_req   = '0;
    squash        = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.fu_rob_packet !== '0) $display("[TB] FAIL reset_rob: got %h want 0", bus.fu_rob_packet);
    else passed++;
    checks++;
    if (bus.cdb_output !== '0) $display("[TB] FAIL reset_cdb: got %h want 0", bus.cdb_output);
    else passed++;
    checks++;
    if (bus.src_ready !== 4'b1111) $display("[TB] FAIL reset_ready: got %b want 1111", bus.src_ready);
    else passed++;
  endtask

  task automatic test_single();
    FU_ROB_PACKET er;
    CDB_PACKET    ec;
    er.robn = 6'd5; er.executed = 1'b1; er.branch_taken = 1'b0; er.target_addr = 32'h1234;
    ec.dest_prn = 6'd7; ec.value = 32'h1234;
    bus.src_valid  = 4'b0100;
    bus.src_req[2] = mk(5, 7, 1'b1, 1'b0, 'h1234);
    @(negedge clock);
    idle_inputs();
    checks++;
    if (bus.fu_rob_packet[0] !== er) $display("[TB] FAIL single_rob0: got %h want %h", bus.fu_rob_packet[0], er);
    else passed++;
    checks++;
    if (bus.cdb_output[0] !== ec) $display("[TB] FAIL single_cdb0: got %h want %h", bus.cdb_output[0], ec);
    else passed++;
    checks++;
    if (bus.fu_rob_packet[1] !== '0 || bus.cdb_output[1] !== '0)
      $display("[TB] FAIL single_lane1: got %h/%h want 0", bus.fu_rob_packet[1], bus.cdb_output[1]);
    else passed++;
    @(negedge clock);
    checks++;
    if (bus.fu_rob_packet !== '0 || bus.cdb_output !== '0)
      $display("[TB] FAIL single_drained: got %h/%h want 0", bus.fu_rob_packet, bus.cdb_output);
    else passed++;
  endtask

  task automatic test_branch();
    FU_ROB_PACKET er;
    er.robn = 6'd9; er.executed = 1'b1; er.branch_taken = 1'b1; er.target_addr = 32'h80;
    bus.src_valid  = 4'b0001;
    bus.src_req[0] = mk(9, 3, 1'b0, 1'b1, 'h80);
    @(negedge clock);
    idle_inputs();
    checks++;
    if (bus.fu_rob_packet[0] !== er) $display("[TB] FAIL branch_rob0: got %h want %h", bus.fu_rob_packet[0], er);
    else passed++;
    checks++;
    if (bus.cdb_output[0] !== '0) $display("[TB] FAIL branch_cdb0: got %h want 0", bus.cdb_output[0]);
    else passed++;
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin
        checks++;
        if (c <= 4 && (bus.fu_rob_packet[0].robn !== ROB_IDX'(c) || bus.fu_rob_packet[0].executed !== 1'b1))
          $display("[TB] FAIL b2b_lane0 c%0d: got %h want robn %0d", c, bus.fu_rob_packet[0], c);
        else if (c > 4 && bus.fu_rob_packet[0] !== '0)
          $display("[TB] FAIL b2b_lane0 c%0d: got %h want 0", c, bus.fu_rob_packet[0]);
        else passed++;
      end
      checks++;
      if (bus.src_ready !== 4'b1111) $display("[TB] FAIL b2b_ready c%0d: got %b want 1111", c, bus.src_ready);
      else passed++;
      bus.src_valid  = (c < 4) ? 4'b0010 : 4'b0000;
      bus.src_req[1] = mk(c + 1, 2, 1'b1, 1'b0, c + 1);
      @(negedge clock);
    end
    idle_inputs();
  endtask

  task automatic test_fairness();
    int       seq [NS];
    logic [NS-1:0] rdy_prev;
    int       e0, e1;
    logic [NS-1:0] erdy;
    for (int i = 0; i < NS; i++) seq[i] = 0;
    rdy_prev = '0;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) begin
`ifdef CDB_ROUND_ROBIN_EN
        if (c % 2 == 1) begin e0 = (c - 1) / 2; e1 = 8 + (c - 1) / 2; end
        else begin e0 = 16 + c / 2 - 1; e1 = 24 + c / 2 - 1; end
        erdy = (c == 1) ? 4'b1111 : ((c % 2 == 0) ? 4'b0011 : 4'b1100);
`else
        e0 = c - 1;
        e1 = 8 + c - 1;
        erdy = (c == 1) ? 4'b1111 : 4'b0011;
`endif
        checks++;
        if (bus.fu_rob_packet[0].robn !== ROB_IDX'(e0) || bus.fu_rob_packet[0].executed !== 1'b1)
          $display("[TB] FAIL fair_lane0 c%0d: got %h want robn %0d", c, bus.fu_rob_packet[0], e0);
        else passed++;
        checks++;
        if (bus.fu_rob_packet[1].robn !== ROB_IDX'(e1) || bus.fu_rob_packet[1].executed !== 1'b1)
          $display("[TB] FAIL fair_lane1 c%0d: got %h want robn %0d", c, bus.fu_rob_packet[1], e1);
        else passed++;
        checks++;
        if (bus.src_ready !== erdy) $display("[TB] FAIL fair_ready c%0d: got %b want %b", c, bus.src_ready, erdy);
        else passed++;
        for (int i = 0; i < NS; i++) if (rdy_prev[i]) seq[i]++;
      end
      rdy_prev = bus.src_ready;
      for (int i = 0; i < NS; i++) bus.src_req[i] = mk(i * 8 + seq[i], i + 1, 1'b1, 1'b0, i * 8 + seq[i]);
      bus.src_valid = 4'b1111;
      @(negedge clock);
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    int   exp_l0 [10] = '{0, 10, 11, 12, 13, 1, 2, 3, 0, 0};
    int   exp_l1 [10] = '{0, 20, 21, 22, 23, 0, 0, 0, 0, 0};
    bit   exp_r3 [10] = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
    int   seq3;
    bit   drove3, rdy3;
    seq3 = 1; drove3 = 1'b0; rdy3 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (drove3 && rdy3) seq3++;
      checks++;
      if (bus.fu_rob_packet[0].robn !== ROB_IDX'(exp_l0[c]) || bus.fu_rob_packet[0].executed !== (exp_l0[c] != 0))
        $display("[TB] FAIL bp_lane0 c%0d: got %h want robn %0d", c, bus.fu_rob_packet[0], exp_l0[c]);
      else passed++;
      checks++;
      if (bus.fu_rob_packet[1].robn !== ROB_IDX'(exp_l1[c]) || bus.fu_rob_packet[1].executed !== (exp_l1[c] != 0))
        $display("[TB] FAIL bp_lane1 c%0d: got %h want robn %0d", c, bus.fu_rob_packet[1], exp_l1[c]);
      else passed++;
      checks++;
      if (bus.src_ready[3] !== exp_r3[c]) $display("[TB] FAIL bp_ready3 c%0d: got %b want %b", c, bus.src_ready[3], exp_r3[c]);
      else passed++;
      rdy3   = bus.src_ready[3];
      drove3 = (seq3 <= 3);
      bus.src_valid  = {drove3, 1'b0, (c <= 3), (c <= 3)};
      bus.src_req[0] = mk(10 + c, 1, 1'b1, 1'b0, 10 + c);
      bus.src_req[1] = mk(20 + c, 2, 1'b1, 1'b0, 20 + c);
      bus.src_req[3] = mk(seq3, 4, 1'b1, 1'b0, seq3);
      @(negedge clock);
    end
    idle_inputs();
  endtask

  task automatic test_squash();
    for (int c = 0; c < 3; c++) begin
      bus.src_valid = 4'b1111;
      for (int i = 0; i < NS; i++) bus.src_req[i] = mk(50 + i, i + 1, 1'b1, 1'b0, 50 + i);
      @(negedge clock);
    end
    squash = 1'b1;
    for (int i = 0; i < NS; i++) bus.src_req[i] = mk(60 + i, i + 1, 1'b1, 1'b0, 60 + i);
    #1;
    checks++;
    if (bus.fu_rob_packet !== '0 || bus.cdb_output !== '0)
      $display("[TB] FAIL squash_cycle: got %h/%h want 0", bus.fu_rob_packet, bus.cdb_output);
    else passed++;
    @(negedge clock);
    idle_inputs();
    checks++;
    if (bus.fu_rob_packet !== '0 || bus.cdb_output !== '0)
      $display("[TB] FAIL squash_stale: got %h/%h want 0", bus.fu_rob_packet, bus.cdb_output);
    else passed++;
    checks++;
    if (bus.src_ready !== 4'b1111) $display("[TB] FAIL squash_ready: got %b want 1111", bus.src_ready);
    else passed++;
    bus.src_valid = 4'b1111;
    for (int i = 0; i < NS; i++) bus.src_req[i] = mk(40 + i, i + 1, 1'b1, 1'b0, 40 + i);
    @(negedge clock);
    idle_inputs();
    checks++;
    if (bus.fu_rob_packet[0].robn !== 6'd40 || bus.fu_rob_packet[0].executed !== 1'b1)
      $display("[TB] FAIL squash_first_lane0: got %h want robn 40", bus.fu_rob_packet[0]);
    else passed++;
    checks++;
    if (bus.fu_rob_packet[1].robn !== 6'd41 || bus.fu_rob_packet[1].executed !== 1'b1)
      $display("[TB] FAIL squash_first_lane1: got %h want robn 41", bus.fu_rob_packet[1]);
    else passed++;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    @(negedge clock);
    test_reset();
    test_single();
    test_branch();
    do_reset();
    test_back_to_back();
    do_reset();
    test_fairness();
`ifndef CDB_ROUND_ROBIN_EN
    do_reset();
    test_backpressure();
`endif
    do_reset();
    test_squash();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
